internal_node_tree: RTL and testbench

INTERNAL_NODE_TREE -- requirements
Module: internal_node_tree

---
 rtl/internal_node_tree_pkg.sv | 22 ++
 rtl/tree_level_stage.sv | 62 ++++++
 rtl/internal_node_tree.sv | 93 +++++++++
 tb/tb_internal_node_tree.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/internal_node_tree_pkg.sv
// Shared constants and node-word layout for the kd-style decision tree.
package internal_node_tree_pkg;

  localparam int unsigned NUM_DIMS       = 5;
  localparam int unsigned DIM_WIDTH      = 11;
  localparam int unsigned TREE_DEPTH     = 6;
  localparam int unsigned NUM_NODES      = 63;
  localparam int unsigned NUM_LEAVES     = 64;
  localparam int unsigned PTR_WIDTH      = TREE_DEPTH;
  localparam int unsigned NODE_IDX_WIDTH = TREE_DEPTH + 1;

  localparam int unsigned DIM_LSB    = 0;
  localparam int unsigned DIM_MSB    = 10;
  localparam int unsigned MEDIAN_LSB = 11;
  localparam int unsigned MEDIAN_MSB = 21;

  typedef struct packed {
    logic signed [DIM_WIDTH-1:0] median;
    logic        [DIM_WIDTH-1:0] dim;
  } node_t;

endpackage

// File: rtl/tree_level_stage.sv
// One tree level: compare the selected patch component with the node median
// and register the chosen child (or the leaf number on the last level).
module tree_level_stage
  import internal_node_tree_pkg::*;
#(
  parameter int unsigned LEVEL          = 0,
  parameter int unsigned INTERNAL_WIDTH = 22,
  parameter int unsigned PATCH_WIDTH    = 55
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_in,
  input  logic [PATCH_WIDTH-1:0]    patch_in,
  input  logic [PTR_WIDTH-1:0]      node_in,
  input  logic [INTERNAL_WIDTH-1:0] node_word,
  output logic [PTR_WIDTH-1:0]      addr_c,
  output logic                      valid_out,
  output logic [PATCH_WIDTH-1:0]    patch_out,
  output logic [PTR_WIDTH-1:0]      node_out
);

  localparam bit LAST = (LEVEL == TREE_DEPTH - 1);

  node_t                     node;
  logic [DIM_WIDTH-1:0]      comp;
  logic                      go_left;
  logic [NODE_IDX_WIDTH-1:0] child;
  logic [PTR_WIDTH-1:0]      next_node;

  assign addr_c = node_in;
  assign node   = node_t'(node_word[MEDIAN_MSB:DIM_LSB]);

  // Out-of-range dim values fall back to component 0.
  always_comb begin
    comp = patch_in[DIM_WIDTH-1:0];
    for (int unsigned k = 1; k < NUM_DIMS; k++) begin
      if (node.dim == DIM_WIDTH'(k)) comp = patch_in[k*DIM_WIDTH +: DIM_WIDTH];
    end
  end

  assign go_left = $signed(comp) < $signed(node.median);
  assign child   = {node_in, 1'b0} + (go_left ? NODE_IDX_WIDTH'(1) : NODE_IDX_WIDTH'(2));

  // The last level converts the heap index into a leaf number.
  assign next_node = LAST ? PTR_WIDTH'(child - NODE_IDX_WIDTH'(NUM_NODES))
                          : PTR_WIDTH'(child);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      patch_out <= '0;
      node_out  <= '0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        patch_out <= patch_in;
        node_out  <= next_node;
      end
    end
  end

endmodule

// File: rtl/internal_node_tree.sv
// Loadable 63-node decision tree with two independent 6-stage query lanes.
module internal_node_tree
  import internal_node_tree_pkg::*;
#(
  parameter int unsigned INTERNAL_WIDTH = 22,
  parameter int unsigned PATCH_WIDTH    = 55,
  parameter int unsigned ADDRESS_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fsm_enable,
  input  logic                      sender_enable,
  input  logic [INTERNAL_WIDTH-1:0] sender_data,
  input  logic                      patch_en,
  input  logic                      patch_two_en,
  input  logic [PATCH_WIDTH-1:0]    patch_in,
  input  logic [PATCH_WIDTH-1:0]    patch_in_two,
  output logic [ADDRESS_WIDTH-1:0]  leaf_index,
  output logic [ADDRESS_WIDTH-1:0]  leaf_index_two,
  output logic                      receiver_en,
  output logic                      receiver_two_en
);

  logic [INTERNAL_WIDTH-1:0] nodes [NUM_LEAVES];
  logic [PTR_WIDTH-1:0]      wptr;
  logic                      wr_en_c;

  // Writes stop once all internal nodes are filled; the pointer never wraps.
  assign wr_en_c = fsm_enable && sender_enable && (wptr < PTR_WIDTH'(NUM_NODES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      for (int i = 0; i < int'(NUM_LEAVES); i++) nodes[i] <= '0;
    end else if (wr_en_c) begin
      nodes[wptr] <= sender_data;
      wptr        <= wptr + PTR_WIDTH'(1);
    end
  end

  for (genvar ln = 0; ln < 2; ln++) begin : g_lane
    logic                      valid [TREE_DEPTH+1];
    logic [PATCH_WIDTH-1:0]    patch [TREE_DEPTH+1];
    logic [PTR_WIDTH-1:0]      node  [TREE_DEPTH+1];
    logic [PTR_WIDTH-1:0]      addr  [TREE_DEPTH];
    logic [INTERNAL_WIDTH-1:0] word  [TREE_DEPTH];
    logic [ADDRESS_WIDTH-1:0]  leaf_q;
    logic                      done_q;

    assign valid[0] = (ln == 0) ? patch_en : patch_two_en;
    assign patch[0] = (ln == 0) ? patch_in : patch_in_two;
    assign node[0]  = '0;

    for (genvar lv = 0; lv < TREE_DEPTH; lv++) begin : g_level
      // Each stage reads live node storage, so in-progress loads are visible.
      assign word[lv] = nodes[addr[lv]];

      tree_level_stage #(
        .LEVEL          (lv),
        .INTERNAL_WIDTH (INTERNAL_WIDTH),
        .PATCH_WIDTH    (PATCH_WIDTH)
      ) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid[lv]),
        .patch_in  (patch[lv]),
        .node_in   (node[lv]),
        .node_word (word[lv]),
        .addr_c    (addr[lv]),
        .valid_out (valid[lv+1]),
        .patch_out (patch[lv+1]),
        .node_out  (node[lv+1])
      );
    end

    // Result register: index holds until the next valid result on this lane.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        leaf_q <= '0;
        done_q <= 1'b0;
      end else begin
        done_q <= valid[TREE_DEPTH];
        if (valid[TREE_DEPTH]) leaf_q <= ADDRESS_WIDTH'(node[TREE_DEPTH]);
      end
    end
  end

  assign leaf_index      = g_lane[0].leaf_q;
  assign leaf_index_two  = g_lane[1].leaf_q;
  assign receiver_en     = g_lane[0].done_q;
  assign receiver_two_en = g_lane[1].done_q;

endmodule

// File: tb/tb_internal_node_tree.sv
// Directed bench for internal_node_tree: loading, traversal, latency, lanes, reset.
module tb_internal_node_tree;

  localparam int unsigned IW = 22;
  localparam int unsigned PW = 55;
  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fsm_enable = 1'b0;
  logic          sender_enable = 1'b0;
  logic [IW-1:0] sender_data = '0;
  logic          patch_en = 1'b0;
  logic          patch_two_en = 1'b0;
  logic [PW-1:0] patch_in = '0;
  logic [PW-1:0] patch_in_two = '0;
  logic [AW-1:0] leaf_index;
  logic [AW-1:0] leaf_index_two;
  logic          receiver_en;
  logic          receiver_two_en;

  int tests = 0;
  int fails = 0;

  internal_node_tree #(
    .INTERNAL_WIDTH (IW),
    .PATCH_WIDTH    (PW),
    .ADDRESS_WIDTH  (AW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fsm_enable      (fsm_enable),
    .sender_enable   (sender_enable),
    .sender_data     (sender_data),
    .patch_en        (patch_en),
    .patch_two_en    (patch_two_en),
    .patch_in        (patch_in),
    .patch_in_two    (patch_in_two),
    .leaf_index      (leaf_index),
    .leaf_index_two  (leaf_index_two),
    .receiver_en     (receiver_en),
    .receiver_two_en (receiver_two_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk_patch(input int c0, input int c1, input int c2,
                                             input int c3, input int c4);
    return {11'(c4), 11'(c3), 11'(c2), 11'(c1), 11'(c0)};
  endfunction

  function automatic logic [IW-1:0] mk_node(input int median, input int dim);
    return {11'(median), 11'(dim)};
  endfunction

  task automatic write_word(input logic [IW-1:0] w, input logic fsm);
    @(negedge clk);
    fsm_enable    = fsm;
    sender_enable = 1'b1;
    sender_data   = w;
  endtask

  task automatic bus_idle();
    @(negedge clk);
    fsm_enable    = 1'b0;
    sender_enable = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Level-driven tree: dim = level (level 5 uses dim 7), median = 10*level,
  // with two hand-placed overrides at nodes 2 and 62.
  task automatic load_tree_b();
    int lvl;
    for (int i = 0; i < 63; i++) begin
      lvl = $clog2(i + 2) - 1;
      if (i == 2)       write_word(mk_node(-100, 4), 1'b1);
      else if (i == 62) write_word(mk_node(50, 1), 1'b1);
      else              write_word(mk_node(10 * lvl, (lvl == 5) ? 7 : lvl), 1'b1);
    end
  endtask

  task automatic run_query(input string tag, input bit use1, input bit use2,
                           input logic [PW-1:0] p1, input logic [PW-1:0] p2,
                           input int exp1, input int exp2);
    int lat;
    lat = 99;
    @(negedge clk);
    patch_en = use1; patch_in = p1;
    patch_two_en = use2; patch_in_two = p2;
    @(negedge clk);
    patch_en = 1'b0; patch_two_en = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if ((use1 && receiver_en) || (use2 && receiver_two_en)) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'd6);
    if (use1) begin
      check({tag, "_valid1"}, 32'(receiver_en), 32'd1);
      check({tag, "_idx1"}, 32'(leaf_index), 32'(exp1));
    end
    if (use2) begin
      check({tag, "_valid2"}, 32'(receiver_two_en), 32'd1);
      check({tag, "_idx2"}, 32'(leaf_index_two), 32'(exp2));
    end
    @(negedge clk);
    @(negedge clk);
    if (use1) begin
      check({tag, "_pulse1_end"}, 32'(receiver_en), 32'd0);
      check({tag, "_hold1"}, 32'(leaf_index), 32'(exp1));
    end
    if (use2) begin
      check({tag, "_pulse2_end"}, 32'(receiver_two_en), 32'd0);
      check({tag, "_hold2"}, 32'(leaf_index_two), 32'(exp2));
    end
  endtask

  initial begin
    logic [PW-1:0] q1, q2, q3, q4, q5;
    int            seen_idx [3];
    int            seen_cyc [3];
    int            nseen;
    int            pulses;

    q1 = mk_patch(60, 20, 25, 35, 45);      // leaf 62
    q2 = mk_patch(-1, 10, 19, 30, -50);     // leaf 20
    q3 = mk_patch(0, 100, -20, 29, 40);     // leaf 50
    q4 = mk_patch(-300, -400, 500, 31, -1); // leaf 12
    q5 = mk_patch(0, 0, 0, 0, -200);        // leaf 32

    @(negedge clk);
    check("rst_leaf", 32'(leaf_index), 32'd0);
    check("rst_leaf_two", 32'(leaf_index_two), 32'd0);
    check("rst_rx", 32'(receiver_en), 32'd0);
    check("rst_rx_two", 32'(receiver_two_en), 32'd0);
    rst_n = 1'b1;

    // All-zero tree: everything left for negative comp0, right otherwise.
    for (int i = 0; i < 63; i++) write_word(mk_node(0, 0), 1'b1);
    bus_idle();
    run_query("zero_neg", 1'b1, 1'b1, mk_patch(-5, 0, 0, 0, 0), mk_patch(7, 0, 0, 0, 0), 0, 63);
    run_query("zero_eq", 1'b1, 1'b0, mk_patch(0, 0, 0, 0, 0), '0, 63, 0);
    run_query("zero_pos", 1'b1, 1'b0, mk_patch(7, 0, 0, 0, 0), '0, 63, 0);

    // Disabled writes first, then the real tree, then surplus writes.
    do_reset();
    write_word(mk_node(1000, 0), 1'b0);
    write_word(mk_node(1000, 0), 1'b0);
    load_tree_b();
    for (int i = 0; i < 7; i++) write_word(mk_node(1000, 0), 1'b1);
    bus_idle();

    run_query("dual", 1'b1, 1'b1, q1, q3, 62, 50);
    run_query("lane1_q2", 1'b1, 1'b0, q2, '0, 20, 0);
    run_query("lane2_q4", 1'b0, 1'b1, '0, q4, 0, 12);
    run_query("lane1_q5", 1'b1, 1'b0, q5, '0, 32, 0);

    // Back-to-back issue on three consecutive cycles.
    @(negedge clk); patch_en = 1'b1; patch_in = q1;
    @(negedge clk); patch_in = q2;
    @(negedge clk); patch_in = q5;
    @(negedge clk); patch_en = 1'b0;
    nseen = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (receiver_en && nseen < 3) begin
        seen_idx[nseen] = int'(leaf_index);
        seen_cyc[nseen] = k;
        nseen++;
      end
    end
    check("b2b_count", 32'(nseen), 32'd3);
    if (nseen == 3) begin
      check("b2b_first_cycle", 32'(seen_cyc[0]), 32'd4);
      check("b2b_gap01", 32'(seen_cyc[1] - seen_cyc[0]), 32'd1);
      check("b2b_gap12", 32'(seen_cyc[2] - seen_cyc[1]), 32'd1);
      check("b2b_idx0", 32'(seen_idx[0]), 32'd62);
      check("b2b_idx1", 32'(seen_idx[1]), 32'd20);
      check("b2b_idx2", 32'(seen_idx[2]), 32'd32);
    end

    // Reset in the middle of an in-flight query on both lanes.
    @(negedge clk);
    patch_en = 1'b1; patch_in = q1; patch_two_en = 1'b1; patch_in_two = q3;
    @(negedge clk);
    patch_en = 1'b0; patch_two_en = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_leaf", 32'(leaf_index), 32'd32);
    check("pre_rst_leaf_two", 32'(leaf_index_two), 32'd12);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_leaf", 32'(leaf_index), 32'd0);
    check("midrst_leaf_two", 32'(leaf_index_two), 32'd0);
    check("midrst_rx", 32'(receiver_en), 32'd0);
    check("midrst_rx_two", 32'(receiver_two_en), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (receiver_en || receiver_two_en) pulses++;
    end
    check("midrst_no_pulse", 32'(pulses), 32'd0);

    // First write after reset lands in node 0.
    write_word(mk_node(100, 0), 1'b1);
    bus_idle();
    run_query("post_rst_node0", 1'b1, 1'b0, mk_patch(50, 0, 0, 0, 0), '0, 31, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
